// File: rtl/robot_json_cmd_rx_if.sv
// Signal bundle between the robot-side command receiver and its environment:
// the serial line in, and the decoded byte / command / error outputs.
interface robot_json_cmd_rx_if;
  logic              iRXD;
  logic        [7:0] oRX_BYTE;
  logic              oRX_BYTE_VALID;
  logic              oCMD_VALID;
  logic signed [7:0] oLEFT;
  logic signed [7:0] oRIGHT;
  logic              oERR;

  // Receiver side: consumes the serial line, drives the decoded results.
  modport slave (
    input  iRXD,
    output oRX_BYTE, oRX_BYTE_VALID, oCMD_VALID, oLEFT, oRIGHT, oERR
  );

  // Environment side: drives the serial line, observes the results.
  modport master (
    output iRXD,
    input  oRX_BYTE, oRX_BYTE_VALID, oCMD_VALID, oLEFT, oRIGHT, oERR
  );
endinterface

// File: rtl/robot_json_cmd_rx.sv
// UART 8N1 receiver feeding a streaming parser for drive commands of the form
// {"T":1,"L":<v>,"R":<v>}\n, producing signed wheel speeds in tenths.
module robot_json_cmd_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  robot_json_cmd_rx_if.slave  bus
);

  localparam int             CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAITHI} ustate_t;
  typedef enum logic [3:0] {P_WAIT, P_LIT, P_TVAL, P_SIGN, P_INT, P_DOT,
                            P_FRAC, P_CLOSE, P_NL} pstate_t;
  typedef enum logic [1:0] {LIT_T, LIT_L, LIT_R} lit_t;

  // Expected character idx of a literal: "T": or ,"L": or ,"R":
  function automatic logic [7:0] lit_char(input lit_t l, input logic [2:0] idx);
    logic [7:0] c;
    if (l == LIT_T) begin
      case (idx)
        3'd0:    c = 8'h22;
        3'd1:    c = 8'h54;
        3'd2:    c = 8'h22;
        default: c = 8'h3A;
      endcase
    end else begin
      case (idx)
        3'd0:    c = 8'h2C;
        3'd1:    c = 8'h22;
        3'd2:    c = (l == LIT_L) ? 8'h4C : 8'h52;
        3'd3:    c = 8'h22;
        default: c = 8'h3A;
      endcase
    end
    return c;
  endfunction

  function automatic logic [2:0] lit_last(input lit_t l);
    return (l == LIT_T) ? 3'd3 : 3'd4;
  endfunction

  function automatic logic signed [7:0] apply_sign(input logic neg, input logic [7:0] mag);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  // UART state
  logic          sync1_q, sync2_q;
  ustate_t       ustate_q, ustate_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          bvalid_q, bvalid_d;
  logic          frame_err;

  // Parser state
  pstate_t           pstate_q, pstate_d;
  lit_t              lit_q, lit_d;
  logic [2:0]        idx_q, idx_d;
  logic              neg_q, neg_d;
  logic [3:0]        int_q, int_d;
  logic signed [7:0] lval_q, lval_d, rval_q, rval_d;
  logic signed [7:0] left_q, left_d, right_q, right_d;
  logic              cmd_q, cmd_d, err_q, err_d;
  logic              pbad, pdone;

  logic              rx_s;
  logic [7:0]        rb;
  logic              dig;
  logic signed [7:0] num_val;

  assign rx_s    = sync2_q;
  assign rb      = byte_q;
  assign dig     = (rb >= 8'h30) && (rb <= 8'h39);
  assign num_val = apply_sign(neg_q, ({4'b0, int_q} * 8'd10) + {4'b0, rb[3:0]});

  // Register all state; reset discards any partial frame or command.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      ustate_q <= U_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      bvalid_q <= 1'b0;
      pstate_q <= P_WAIT;
      lit_q    <= LIT_T;
      idx_q    <= '0;
      neg_q    <= 1'b0;
      int_q    <= '0;
      lval_q   <= '0;
      rval_q   <= '0;
      left_q   <= '0;
      right_q  <= '0;
      cmd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= bus.iRXD;
      sync2_q  <= sync1_q;
      ustate_q <= ustate_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      bvalid_q <= bvalid_d;
      pstate_q <= pstate_d;
      lit_q    <= lit_d;
      idx_q    <= idx_d;
      neg_q    <= neg_d;
      int_q    <= int_d;
      lval_q   <= lval_d;
      rval_q   <= rval_d;
      left_q   <= left_d;
      right_q  <= right_d;
      cmd_q    <= cmd_d;
      err_q    <= err_d;
    end
  end

  // UART next state: start qualification at mid-bit, 8 data bits, stop check.
  always_comb begin
    ustate_d = ustate_q;
    case (ustate_q)
      U_IDLE:   if (!rx_s) ustate_d = U_START;
      U_START:  if (cnt_q == HALF) ustate_d = rx_s ? U_IDLE : U_DATA;
      U_DATA:   if (cnt_q == FULL && bit_q == 3'd7) ustate_d = U_STOP;
      U_STOP:   if (cnt_q == FULL) ustate_d = rx_s ? U_IDLE : U_WAITHI;
      U_WAITHI: if (rx_s) ustate_d = U_IDLE;
      default:  ustate_d = U_IDLE;
    endcase
  end

  // UART datapath: bit timing, LSB-first shifting, byte delivery / framing error.
  always_comb begin
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    bvalid_d  = 1'b0;
    frame_err = 1'b0;
    case (ustate_q)
      U_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
      end
      U_DATA: if (cnt_q == FULL) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
      end
      U_STOP: if (cnt_q == FULL) begin
        cnt_d = '0;
        if (rx_s) begin
          byte_d   = shift_q;
          bvalid_d = 1'b1;
        end else begin
          frame_err = 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Parser next state: one step per delivered byte; bad bytes abort (or restart on '{').
  always_comb begin
    pstate_d = pstate_q;
    lit_d    = lit_q;
    idx_d    = idx_q;
    pbad     = 1'b0;
    pdone    = 1'b0;
    if (frame_err) begin
      pstate_d = P_WAIT;
    end else if (bvalid_q) begin
      case (pstate_q)
        P_WAIT: if (rb == 8'h7B) begin
          pstate_d = P_LIT;
          lit_d    = LIT_T;
          idx_d    = '0;
        end
        P_LIT: if (rb == lit_char(lit_q, idx_q)) begin
          if (idx_q == lit_last(lit_q)) pstate_d = (lit_q == LIT_T) ? P_TVAL : P_SIGN;
          else idx_d = idx_q + 3'd1;
        end else pbad = 1'b1;
        P_TVAL: if (rb == 8'h31) begin
          pstate_d = P_LIT;
          lit_d    = LIT_L;
          idx_d    = '0;
        end else pbad = 1'b1;
        P_SIGN: begin
          if (rb == 8'h2D)      pstate_d = P_INT;
          else if (dig)         pstate_d = P_DOT;
          else if (rb == 8'h2E) pstate_d = P_FRAC;
          else                  pbad = 1'b1;
        end
        P_INT: begin
          if (dig)              pstate_d = P_DOT;
          else if (rb == 8'h2E) pstate_d = P_FRAC;
          else                  pbad = 1'b1;
        end
        P_DOT: if (rb == 8'h2E) pstate_d = P_FRAC; else pbad = 1'b1;
        // Left number is followed by ,"R": ; right number by the closing brace.
        P_FRAC: if (dig) begin
          if (lit_q == LIT_R) pstate_d = P_CLOSE;
          else begin
            pstate_d = P_LIT;
            lit_d    = LIT_R;
            idx_d    = '0;
          end
        end else pbad = 1'b1;
        P_CLOSE: if (rb == 8'h7D) pstate_d = P_NL; else pbad = 1'b1;
        P_NL: if (rb == 8'h0A) begin
          pstate_d = P_WAIT;
          pdone    = 1'b1;
        end else pbad = 1'b1;
        default: pstate_d = P_WAIT;
      endcase
      if (pbad) begin
        if (rb == 8'h7B) begin
          pstate_d = P_LIT;
          lit_d    = LIT_T;
          idx_d    = '0;
        end else begin
          pstate_d = P_WAIT;
        end
      end
    end
  end

  // Parser outputs: number accumulation, command commit, error pulse.
  always_comb begin
    neg_d   = neg_q;
    int_d   = int_q;
    lval_d  = lval_q;
    rval_d  = rval_q;
    left_d  = left_q;
    right_d = right_q;
    cmd_d   = pdone;
    err_d   = frame_err | pbad;
    if (bvalid_q && !pbad) begin
      case (pstate_q)
        P_SIGN: begin
          neg_d = (rb == 8'h2D);
          int_d = dig ? rb[3:0] : 4'd0;
        end
        P_INT: int_d = dig ? rb[3:0] : 4'd0;
        P_FRAC: begin
          if (lit_q == LIT_R) rval_d = num_val;
          else                lval_d = num_val;
        end
        P_NL: begin
          left_d  = lval_q;
          right_d = rval_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.oRX_BYTE       = byte_q;
  assign bus.oRX_BYTE_VALID = bvalid_q;
  assign bus.oCMD_VALID     = cmd_q;
  assign bus.oLEFT          = left_q;
  assign bus.oRIGHT         = right_q;
  assign bus.oERR           = err_q;

endmodule

// File: tb/tb_robot_json_cmd_rx.sv
// Bench for robot_json_cmd_rx: directed scenarios plus randomized commands,
// with expected speeds computed from the command fields.
module tb_robot_json_cmd_rx;
  localparam int CPB = 16;

  logic clk;
  logic rst_n;
  robot_json_cmd_rx_if bus();

  robot_json_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int bit_t = CPB * 10;

  // Event observation
  int         n_cmd = 0, n_err = 0, n_byte = 0;
  int         q_l[$], q_r[$];
  logic       prev_bv = 1'b0;
  logic [7:0] prev_b = 8'h00;
  logic [7:0] bad_byte = 8'h00;
  logic       frame_ok = 1'b0;

  always @(negedge clk) begin
    if (bus.oCMD_VALID === 1'b1) begin
      n_cmd++;
      q_l.push_back(int'(bus.oLEFT));
      q_r.push_back(int'(bus.oRIGHT));
      checks++;
      assert (prev_bv === 1'b1 && prev_b === 8'h0A) else begin
        failures++;
        $error("FAIL cmd_latency prev_valid=%0b prev_byte=%0h required 1/0a", prev_bv, prev_b);
      end
      checks++;
      assert (bus.oERR === 1'b0) else begin
        failures++;
        $error("FAIL cmd_err_exclusive err=%0b required 0", bus.oERR);
      end
    end
    if (bus.oERR === 1'b1) begin
      n_err++;
      checks++;
      assert ((prev_bv === 1'b1 && prev_b === bad_byte) || (prev_bv === 1'b0 && frame_ok)) else begin
        failures++;
        $error("FAIL err_cause prev_valid=%0b prev_byte=%0h required byte %0h or framing=%0b",
               prev_bv, prev_b, bad_byte, frame_ok);
      end
    end
    if (bus.oRX_BYTE_VALID === 1'b1) n_byte++;
    prev_bv = bus.oRX_BYTE_VALID;
    prev_b  = bus.oRX_BYTE;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d required=%0d", tag, got, exp);
    end
  endtask

  int cmd0, err0, byte0;
  task automatic snap();
    cmd0 = n_cmd; err0 = n_err; byte0 = n_byte;
  endtask

  task automatic expect_state(input string tag, input int dcmd, input int derr, input int dbyte,
                              input int el, input int er);
    chk({tag, "_cmds"},  n_cmd - cmd0, dcmd);
    chk({tag, "_errs"},  n_err - err0, derr);
    chk({tag, "_bytes"}, n_byte - byte0, dbyte);
    chk({tag, "_left"},  int'(bus.oLEFT), el);
    chk({tag, "_right"}, int'(bus.oRIGHT), er);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.iRXD = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      bus.iRXD = b[i];
      #(bit_t);
    end
    bus.iRXD = stop;
    #(bit_t);
    bus.iRXD = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s.getc(i), 1'b1);
  endtask

  task automatic idle();
    #(3 * bit_t);
  endtask

  function automatic string num(input bit n, input bit h, input int i, input int f);
    string s;
    s = "";
    if (n) s = "-";
    if (h) s = {s, $sformatf("%0d", i)};
    s = {s, $sformatf(".%0d", f)};
    return s;
  endfunction

  function automatic int val(input bit n, input bit h, input int i, input int f);
    int m;
    m = (h ? i : 0) * 10 + f;
    return n ? -m : m;
  endfunction

  function automatic string cmd_str(input string l, input string r);
    return {"{\"T\":1,\"L\":", l, ",\"R\":", r, "}\n"};
  endfunction

  string s, s2;
  int    exp_l, exp_r;

  initial begin
    bus.iRXD = 1'b1;
    rst_n    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_left",   int'(bus.oLEFT), 0);
    chk("reset_right",  int'(bus.oRIGHT), 0);
    chk("reset_byte",   int'(bus.oRX_BYTE), 0);
    chk("reset_bvalid", int'(bus.oRX_BYTE_VALID), 0);
    chk("reset_cmd",    int'(bus.oCMD_VALID), 0);
    chk("reset_err",    int'(bus.oERR), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #(2 * bit_t);

    // T1: basic command
    snap();
    s = cmd_str(num(0, 1, 0, 1), num(0, 1, 0, 1));
    send_str(s);
    idle();
    expect_state("T1", 1, 0, s.len(), 1, 1);
    chk("T1_last_byte", int'(bus.oRX_BYTE), 8'h0A);

    // T2: two back-to-back commands, missing int digit, extreme values
    snap();
    s  = cmd_str(num(1, 0, 0, 1), num(0, 1, 0, 1));
    s2 = cmd_str(num(1, 1, 9, 9), num(0, 1, 9, 9));
    send_str({s, s2});
    idle();
    expect_state("T2", 2, 0, s.len() + s2.len(), -99, 99);
    if (q_l.size() >= cmd0 + 2) begin
      chk("T2_first_left",  q_l[cmd0], -1);
      chk("T2_first_right", q_r[cmd0], 1);
    end else begin
      chk("T2_queue_depth", q_l.size(), cmd0 + 2);
    end

    // T3: bad T value after a good +1/+1 command
    s = cmd_str(num(0, 1, 0, 1), num(0, 1, 0, 1));
    send_str(s);
    idle();
    snap();
    s.putc(5, 8'h32);
    bad_byte = 8'h32;
    send_str(s);
    idle();
    expect_state("T3", 0, 1, s.len(), 1, 1);

    // T4: framing error then a valid stop command
    snap();
    frame_ok = 1'b1;
    send_byte(8'h41, 1'b0);
    idle();
    frame_ok = 1'b0;
    expect_state("T4_frame", 0, 1, 0, 1, 1);
    snap();
    s = cmd_str(num(0, 1, 0, 0), num(0, 1, 0, 0));
    send_str(s);
    idle();
    expect_state("T4_cmd", 1, 0, s.len(), 0, 0);

    // T5: short low glitch is ignored
    snap();
    bus.iRXD = 1'b0;
    #(bit_t / 4);
    bus.iRXD = 1'b1;
    idle();
    expect_state("T5_glitch", 0, 0, 0, 0, 0);
    snap();
    s = cmd_str(num(0, 1, 0, 1), num(1, 0, 0, 1));
    send_str(s);
    idle();
    expect_state("T5_cmd", 1, 0, s.len(), 1, -1);

    // Unexpected '{' mid-command restarts parsing and still flags an error
    snap();
    bad_byte = 8'h7B;
    s  = "{\"T\":1,\"L\":";
    s2 = cmd_str(num(0, 1, 5, 5), num(1, 1, 3, 0));
    send_str({s, s2});
    idle();
    expect_state("restart", 1, 1, s.len() + s2.len(), 55, -30);

    // Clock mismatch: sender slow then fast
    bit_t = 163;
    snap();
    s = cmd_str(num(0, 1, 2, 3), num(1, 1, 4, 5));
    send_str(s);
    idle();
    expect_state("baud_slow", 1, 0, s.len(), 23, -45);
    bit_t = 157;
    snap();
    s = cmd_str(num(1, 0, 0, 7), num(0, 1, 9, 0));
    send_str(s);
    idle();
    expect_state("baud_fast", 1, 0, s.len(), -7, 90);
    bit_t = CPB * 10;

    // Randomized commands, some with one byte replaced by an illegal character
    exp_l = -7;
    exp_r = 90;
    bad_byte = 8'h58;
    for (int k = 0; k < 5; k++) begin
      bit ln, lh, rn, rh, bad;
      int li, lf, ri, rf, pos;
      ln = 1'($urandom_range(0, 1)); lh = 1'($urandom_range(0, 1));
      rn = 1'($urandom_range(0, 1)); rh = 1'($urandom_range(0, 1));
      li = $urandom_range(0, 9); lf = $urandom_range(0, 9);
      ri = $urandom_range(0, 9); rf = $urandom_range(0, 9);
      bad = ($urandom_range(0, 2) == 0);
      s = cmd_str(num(ln, lh, li, lf), num(rn, rh, ri, rf));
      snap();
      if (bad) begin
        pos = $urandom_range(1, s.len() - 1);
        s.putc(pos, 8'h58);
        send_str(s);
        idle();
        expect_state($sformatf("rnd%0d_bad", k), 0, 1, s.len(), exp_l, exp_r);
      end else begin
        exp_l = val(ln, lh, li, lf);
        exp_r = val(rn, rh, ri, rf);
        send_str(s);
        idle();
        expect_state($sformatf("rnd%0d", k), 1, 0, s.len(), exp_l, exp_r);
      end
    end

    // T6: reset in the middle of the left number
    snap();
    s = cmd_str(num(0, 1, 1, 2), num(0, 1, 3, 4));
    send_str(s);
    idle();
    expect_state("T6_pre", 1, 0, s.len(), 12, 34);
    send_str("{\"T\":1,\"L\":-");
    bus.iRXD = 1'b0;
    #(3 * bit_t);
    rst_n = 1'b0;
    #1;
    chk("T6_rst_left",   int'(bus.oLEFT), 0);
    chk("T6_rst_right",  int'(bus.oRIGHT), 0);
    chk("T6_rst_byte",   int'(bus.oRX_BYTE), 0);
    chk("T6_rst_bvalid", int'(bus.oRX_BYTE_VALID), 0);
    chk("T6_rst_cmd",    int'(bus.oCMD_VALID), 0);
    chk("T6_rst_err",    int'(bus.oERR), 0);
    bus.iRXD = 1'b1;
    #(2 * bit_t);
    @(negedge clk);
    rst_n = 1'b1;
    #(2 * bit_t);
    snap();
    s = cmd_str(num(0, 1, 0, 1), num(0, 1, 0, 1));
    send_str(s);
    idle();
    expect_state("T6_resend", 1, 0, s.len(), 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
